// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default base address, status field layout,
// captured request payload and a byte-strobe merge helper.
package apb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'd1000;

    // status register: [15:0] good transfers, [31:16] errored transfers
    localparam int unsigned OK_CNT_LSB  = 0;
    localparam int unsigned OK_CNT_MSB  = 15;
    localparam int unsigned ERR_CNT_LSB = 16;
    localparam int unsigned ERR_CNT_MSB = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } apb_req_t;

    function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_regbank_slave_if.sv
// APB bus bundle between requester and completer.
interface apb_regbank_slave_if;
    import apb_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational APB register decode: word index plus error flag for
// misaligned, below-base, out-of-range, or read-only-status writes.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned       NUM_REGS  = 8,
    parameter int unsigned       IDX_W     = 3
) (
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    output logic [IDX_W-1:0]  idx,
    output logic              err
);

    localparam int unsigned WORD_W = ADDR_W - 2;

    logic [WORD_W-1:0] word;

    always_comb begin
        word = WORD_W'((paddr - BASE_ADDR) >> 2);
        idx  = word[IDX_W-1:0];
        err  = (paddr[1:0] != 2'b00)
            || (paddr < BASE_ADDR)
            || (word >= WORD_W'(NUM_REGS))
            || (pwrite && (word == WORD_W'(NUM_REGS - 1)));
    end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB completer with a byte-strobed register bank, fixed wait states and a
// read-only status register counting good and errored transfers.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       NUM_REGS    = 8,
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    apb_regbank_slave_if.slave  apb
);

    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STAT_IX = NUM_REGS - 1;

    apb_state_e        state;
    apb_req_t          req;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]  dec_idx;
    logic              dec_err;

    // decode runs on the captured setup-phase request, not the live bus
    apb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_addr_decode (
        .paddr  (req.addr),
        .pwrite (req.write),
        .idx    (dec_idx),
        .err    (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req         <= '0;
            apb.PRDATA  <= '0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            apb.PRDATA  <= '0;
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;

            case (state)
                IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) begin
                        req.addr  <= apb.PADDR;
                        req.write <= apb.PWRITE;
                        req.wdata <= apb.PWDATA;
                        req.strb  <= apb.PSTRB;
                        cnt       <= CNT_W'(WAIT_STATES);
                        state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (apb.PENABLE) begin
                        state      <= DONE;
                        apb.PREADY <= 1'b1;
                        if (dec_err) begin
                            apb.PSLVERR <= 1'b1;
                            regs[STAT_IX][ERR_CNT_MSB:ERR_CNT_LSB] <=
                                regs[STAT_IX][ERR_CNT_MSB:ERR_CNT_LSB] + 16'd1;
                        end else begin
                            if (req.write) begin
                                regs[dec_idx] <= apply_strb(regs[dec_idx], req.wdata, req.strb);
                            end else begin
                                // status reads see the count before this transfer's increment
                                apb.PRDATA <= regs[dec_idx];
                            end
                            regs[STAT_IX][OK_CNT_MSB:OK_CNT_LSB] <=
                                regs[STAT_IX][OK_CNT_MSB:OK_CNT_LSB] + 16'd1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: three builds (1, 0, 3 wait states) checked
// against an array-based register/status model.
module tb_apb_regbank_slave;
    import apb_pkg::*;

    localparam int unsigned       N    = 8;
    localparam logic [31:0]       BASE = 32'd1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          dsel = 0;

    logic [31:0] prdata;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [3][N];
    logic [15:0] mok   [3];
    logic [15:0] merr  [3];

    always #5 clk = ~clk;

    apb_regbank_slave_if if0();
    apb_regbank_slave_if if1();
    apb_regbank_slave_if if2();

    assign if0.PSEL = psel && (dsel == 0);
    assign if1.PSEL = psel && (dsel == 1);
    assign if2.PSEL = psel && (dsel == 2);
    assign if0.PENABLE = penable; assign if1.PENABLE = penable; assign if2.PENABLE = penable;
    assign if0.PWRITE  = pwrite;  assign if1.PWRITE  = pwrite;  assign if2.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;   assign if1.PADDR   = paddr;   assign if2.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;  assign if1.PWDATA  = pwdata;  assign if2.PWDATA  = pwdata;
    assign if0.PSTRB   = pstrb;   assign if1.PSTRB   = pstrb;   assign if2.PSTRB   = pstrb;

    apb_regbank_slave #(.BASE_ADDR(BASE), .NUM_REGS(N), .WAIT_STATES(1)) dut0 (.clk(clk), .rst(rst), .apb(if0));
    apb_regbank_slave #(.BASE_ADDR(BASE), .NUM_REGS(N), .WAIT_STATES(0)) dut1 (.clk(clk), .rst(rst), .apb(if1));
    apb_regbank_slave #(.BASE_ADDR(BASE), .NUM_REGS(N), .WAIT_STATES(3)) dut2 (.clk(clk), .rst(rst), .apb(if2));

    always_comb begin
        case (dsel)
            0:       begin prdata = if0.PRDATA; pready = if0.PREADY; pslverr = if0.PSLVERR; end
            1:       begin prdata = if1.PRDATA; pready = if1.PREADY; pslverr = if1.PSLVERR; end
            default: begin prdata = if2.PRDATA; pready = if2.PREADY; pslverr = if2.PSLVERR; end
        endcase
    end

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=0x%08h expected=0x%08h", tag, dsel, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < int'(N); i++) mregs[d][i] = '0;
            mok[d]  = '0;
            merr[d] = '0;
        end
    endtask

    // One full transfer; setup begins in the current cycle, returns one cycle after PREADY.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd);
        logic [31:0]  off;
        int unsigned  widx;
        bit           e;
        logic [31:0]  exp_rd;
        int           k;

        off    = addr - BASE;
        widx   = off >> 2;
        e      = (addr < BASE) || (addr[1:0] != 2'b00) || (widx >= N) || (wr && widx == N - 1);
        exp_rd = '0;
        if (!e && !wr) exp_rd = (widx == N - 1) ? {merr[dsel], mok[dsel]} : mregs[dsel][widx];

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        k = 1;
        while (pready !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'(2 + ws_of(dsel)));
        check("pslverr", 32'(pslverr), 32'(e));
        check("prdata", prdata, exp_rd);
        rd = prdata;

        if (e) merr[dsel]++;
        else begin
            if (wr) mregs[dsel][widx] = apply_strb(mregs[dsel][widx], wd, strb);
            mok[dsel]++;
        end

        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("pready_single", 32'(pready), 32'd0);
        check("prdata_idle", prdata, 32'd0);
    endtask

    // Setup phase followed by PSEL dropping in the first access cycle.
    task automatic xfer_abort(input logic [31:0] addr, input logic [31:0] wd);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd; pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < ws_of(dsel) + 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_pready", 32'(pready), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            check("rst_pready", 32'(pready), 32'd0);
            check("rst_pslverr", 32'(pslverr), 32'd0);
            check("rst_prdata", prdata, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // basic read, strobed write, readback
        dsel = 0;
        xfer(1'b0, BASE, 32'h0, 4'h0, rd);
        check("first_read_zero", rd, 32'd0);
        xfer(1'b1, BASE + 4, 32'hDEADBEEF, 4'b0101, rd);
        xfer(1'b0, BASE + 4, 32'h0, 4'h0, rd);
        check("strobe_merge", rd, 32'h00AD00EF);
        xfer(1'b0, BASE + 28, 32'h0, 4'h0, rd);
        check("status_after_3", rd, 32'h0000_0003);

        // error cases leave registers alone and count in the upper field
        xfer(1'b0, BASE + 2,  32'h0, 4'h0, rd);
        xfer(1'b0, BASE + 32, 32'h0, 4'h0, rd);
        xfer(1'b1, BASE + 28, 32'hFFFFFFFF, 4'hF, rd);
        xfer(1'b0, BASE - 4,  32'h0, 4'h0, rd);
        xfer(1'b0, BASE + 28, 32'h0, 4'h0, rd);
        check("status_errs", rd, 32'h0004_0004);
        xfer(1'b0, BASE + 4, 32'h0, 4'h0, rd);
        check("reg_unchanged", rd, 32'h00AD00EF);

        // PSEL abort leaves no trace
        xfer_abort(BASE, 32'h12345678);
        xfer(1'b0, BASE, 32'h0, 4'h0, rd);
        check("abort_no_write", rd, 32'd0);

        // back-to-back on zero and three wait-state builds
        for (int d = 1; d < 3; d++) begin
            dsel = d;
            xfer(1'b1, BASE,     32'h11223344, 4'hF, rd);
            xfer(1'b1, BASE + 8, 32'h55667788, 4'hF, rd);
            xfer(1'b0, BASE + 8, 32'h0, 4'h0, rd);
            check("b2b_readback", rd, 32'h55667788);
        end

        // reset on the completion edge of a zero-wait write
        dsel = 1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 8; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_pready", 32'(pready), 32'd0);
        check("rst_mid_prdata", prdata, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        xfer(1'b0, BASE + 8, 32'h0, 4'h0, rd);
        check("rst_mid_no_write", rd, 32'd0);
        xfer(1'b0, BASE + 28, 32'h0, 4'h0, rd);
        check("rst_mid_status", rd, 32'h0000_0001);

        // randomized traffic on every build
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            for (int t = 0; t < 30; t++) begin
                int unsigned r;
                logic [31:0] a;
                r = $urandom_range(0, 15);
                if (r < 10)       a = BASE + 32'(4 * r);
                else if (r == 10) a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                else if (r == 11) a = BASE - 32'(4 * $urandom_range(1, 4));
                else              a = BASE + 32'(4 * $urandom_range(0, 6));
                if ($urandom_range(0, 9) == 0) xfer_abort(a, $urandom);
                else xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
            end
            xfer(1'b0, BASE + 28, 32'h0, 4'h0, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
